// File: rtl/zigzag_scan_ctrl_pkg.sv
// Shared JPEG zigzag scan constants: block size and the zigzag-to-raster table.
// The same table drives the decoder's inverse scan, so keep it the single source.
package jpeg_zz_pkg;

  localparam int BLK_SIZE = 64;
  localparam int IDX_W    = $clog2(BLK_SIZE);

  // Entry k is the raster address (row*8 + col) of zigzag position k.
  localparam logic [IDX_W-1:0] ZZ_ORDER [0:BLK_SIZE-1] = '{
     6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
     6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
     6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
     6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
     6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
     6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
     6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
     6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [IDX_W-1:0] zz_to_raster(input logic [IDX_W-1:0] idx);
    return ZZ_ORDER[idx];
  endfunction

endpackage

// File: rtl/zigzag_scan_ctrl_if.sv
// Raster-in / zigzag-out stream bundle; slave is the controller's view, master the
// surrounding pipeline's view (quantizer upstream, entropy coder downstream).
interface zigzag_scan_ctrl_if
  import jpeg_zz_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/zigzag_scan_ctrl_buf.sv
// Two 64-entry coefficient banks: synchronous write port, combinational read port.
// Contents clear on reset so a discarded partial block never leaks into later output.
module zz_pingpong_buf
  import jpeg_zz_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_wr_bank,
  input  logic [IDX_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_bank,
  input  logic [IDX_W-1:0]  i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2][BLK_SIZE];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < BLK_SIZE; a++) begin
          r_mem[b][a] <= '0;
        end
      end
    end else if (i_we) begin
      r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_bank][i_rd_addr];

endmodule

// File: rtl/zigzag_scan_ctrl.sv
// Ping-pong zigzag scan: raster beats fill one bank while the other replays in zigzag
// order; out_valid rises the cycle after a block's 64th accept, 1 sample/clk each side.
module zigzag_scan_ctrl
  import jpeg_zz_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  zigzag_scan_ctrl_if.slave  io
);

  localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(BLK_SIZE - 1);

  logic [IDX_W-1:0]  r_wr_cnt;
  logic [IDX_W-1:0]  r_rd_cnt;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [1:0]        r_full;
  logic [1:0]        w_full_nxt;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_wr_done;
  logic              w_rd_done;
  logic [IDX_W-1:0]  w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  // Both handshakes see only registered flags, so in_ready never depends on out_ready.
  assign w_in_fire  = io.in_valid && !r_full[r_wr_bank];
  assign w_out_fire = r_full[r_rd_bank] && io.out_ready;
  assign w_wr_done  = w_in_fire && (r_wr_cnt == CNT_MAX);
  assign w_rd_done  = w_out_fire && (r_rd_cnt == CNT_MAX);

  // A completing write and a completing read always target different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_done) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_rd_done) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_full    <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_in_fire) begin
        r_wr_cnt <= r_wr_cnt + IDX_W'(1);
      end
      if (w_wr_done) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_out_fire) begin
        r_rd_cnt <= r_rd_cnt + IDX_W'(1);
      end
      if (w_rd_done) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  assign w_rd_addr = zz_to_raster(r_rd_cnt);

  zz_pingpong_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_in_fire),
    .i_wr_bank (r_wr_bank),
    .i_wr_addr (r_wr_cnt),
    .i_wr_data (io.in_data),
    .i_rd_bank (r_rd_bank),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign io.in_ready  = !r_full[r_wr_bank];
  assign io.out_valid = r_full[r_rd_bank];
  assign io.out_data  = w_rd_data;
  assign io.out_idx   = r_rd_cnt;
  assign io.out_last  = r_full[r_rd_bank] && (r_rd_cnt == CNT_MAX);

endmodule
